dshot_frame_tx: RTL

- Downstream consumer of the baud/phase generator.
- Accepts an 11-bit throttle value and a telemetry-request bit, then appends the 4-bit DShot CRC.
- Serialises the 16-bit frame MSB-first onto one ESC pin.
- Gates the generator via baud_enable; pulse widths come from the generator's half/quarter phase outputs, then an inter-frame idle gap follows.

---
 rtl/dshot_frame_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dshot_frame_tx.sv
// DShot frame transmitter: builds {throttle, telem, crc} and serialises it MSB-first,
// shaping each bit from the baud generator's half/quarter phases, then holds an idle gap.
module dshot_frame_tx #(
  parameter bit          INVERTED = 1'b0,
  parameter int unsigned GAP_BITS = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [10:0] throttle,
  input  logic        telem,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic        baud_enable,
  input  logic        bit_tick,
  input  logic        half_phase,
  input  logic        quarter_phase,
  output logic        dshot_out,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic       IDLE_LEVEL = INVERTED;
  localparam logic [3:0] GAP_LAST   = 4'(GAP_BITS - 1);

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        baud_enable_q, baud_enable_d;
  logic        dshot_out_q, dshot_out_d;
  logic        frame_done_q, frame_done_d;
  logic        accept;
  logic        raw;

  function automatic logic [3:0] dshot_crc(input logic [11:0] v);
    logic [3:0] c;
    c = v[3:0] ^ v[7:4] ^ v[11:8];
    return INVERTED ? ~c : c;
  endfunction

  // The done cycle keeps ready low so a held frame_valid re-accepts one cycle later.
  assign frame_ready = (state_q == ST_IDLE) && !frame_done_q && !reset;
  assign accept      = frame_valid && frame_ready;
  assign baud_enable = baud_enable_q;
  assign dshot_out   = dshot_out_q;
  assign busy        = (state_q == ST_SEND) || (state_q == ST_GAP);
  assign frame_done  = frame_done_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    shift_d       = shift_q;
    bit_idx_d     = bit_idx_q;
    gap_cnt_d     = gap_cnt_q;
    baud_enable_d = baud_enable_q;
    frame_done_d  = 1'b0;
    dshot_out_d   = IDLE_LEVEL;
    raw           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d       = {throttle, telem, dshot_crc({throttle, telem})};
          bit_idx_d     = 4'd0;
          baud_enable_d = 1'b1;
          state_d       = ST_SEND;
        end
      end
      ST_SEND: begin
        // 1-bit: high for quadrants 0-2; 0-bit: high for quadrant 0 only.
        raw         = shift_q[15] ? ~(half_phase & quarter_phase) : ~(half_phase | quarter_phase);
        dshot_out_d = raw ^ IDLE_LEVEL;
        if (bit_tick) begin
          shift_d   = {shift_q[14:0], 1'b0};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd15) begin
            gap_cnt_d = 4'd0;
            state_d   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (bit_tick) begin
          if (gap_cnt_q == GAP_LAST) begin
            baud_enable_d = 1'b0;
            frame_done_d  = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q       <= ST_IDLE;
      shift_q       <= 16'h0000;
      bit_idx_q     <= 4'd0;
      gap_cnt_q     <= 4'd0;
      baud_enable_q <= 1'b0;
      dshot_out_q   <= IDLE_LEVEL;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_idx_q     <= bit_idx_d;
      gap_cnt_q     <= gap_cnt_d;
      baud_enable_q <= baud_enable_d;
      dshot_out_q   <= dshot_out_d;
      frame_done_q  <= frame_done_d;
    end
  end

endmodule
